// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg
// Shared types and constants for the LED mode controller.
//   mode_e        : LED modes, encoded as seen on the 2-bit mode output
//   press_state_e : states of the press classifier
//   DIM_DUTY      : PWM on-steps out of 16 in dimmed ON mode (LED_DIM_EN)
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_ON         = 2'd1,
    MODE_BLINK_SLOW = 2'd2,
    MODE_BLINK_FAST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    P_IDLE      = 2'd0,
    P_PRESSED   = 2'd1,
    P_LONG_HELD = 2'd2
  } press_state_e;

  localparam int unsigned DIM_DUTY = 4;
  localparam int unsigned PWM_W    = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_press_classifier.sv
// ---------------------------------------------------------------------------
// press_classifier
// Turns the debounced button level into one-cycle short/long press pulses.
// A press starts on a 0->1 edge of btn_level. Holding it until the hold
// counter reaches LONG_CYCLES-1 yields press_long (and nothing on release);
// releasing earlier yields press_short.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   btn_level    : debounced button level, 1 = pressed
//   press_short  : one-cycle pulse per short press (registered)
//   press_long   : one-cycle pulse per long press (registered)
//   state_dbg    : current classifier state, for observation only
// ---------------------------------------------------------------------------
module press_classifier
  import led_ctrl_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 62_500_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_level,
  output logic         press_short,
  output logic         press_long,
  output press_state_e state_dbg
);

  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  press_state_e      state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              btn_q;
  logic              short_q, short_d;
  logic              long_q, long_d;

  // Saturating increment so a very long hold can never wrap back into range.
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      P_IDLE: begin
        if (btn_level && !btn_q) begin
          state_d = P_PRESSED;
          hold_d  = '0;
        end
      end
      P_PRESSED: begin
        if (btn_level) begin
          hold_d = hold_inc;
          if (hold_inc == HOLD_LAST) begin
            long_d  = 1'b1;
            state_d = P_LONG_HELD;
          end
        end else begin
          short_d = 1'b1;
          state_d = P_IDLE;
        end
      end
      P_LONG_HELD: begin
        if (btn_level) begin
          hold_d = hold_inc;
        end else begin
          state_d = P_IDLE;
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  // btn_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P_IDLE;
      hold_q  <= '0;
      btn_q   <= 1'b1;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      btn_q   <= btn_level;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign press_short = short_q;
  assign press_long  = long_q;
  assign state_dbg   = state_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
// Steps the board LED through OFF, ON, BLINK_SLOW, BLINK_FAST from a single
// debounced button. Short press advances the mode (wrapping 3 -> 0); long
// press returns to OFF. Entering a blink mode starts with the LED lit and a
// fresh half-period.
// Optional build macro LED_DIM_EN: ON mode drives a 16-step PWM at
// DIM_DUTY/16 duty instead of a constant 1.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   btn_level    : debounced button level, 1 = pressed
//   led          : LED drive (registered)
//   mode         : current mode 0..3 (registered)
//   press_short  : one-cycle pulse per short press
//   press_long   : one-cycle pulse per long press
// Handshake: none; btn_level is a level sampled every cycle, pulses are
// single-cycle strobes with no back-pressure.
// ---------------------------------------------------------------------------
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 62_500_000,
  parameter int unsigned SLOW_HALF   = 25_000_000,
  parameter int unsigned FAST_HALF   = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       led,
  output logic [1:0] mode,
  output logic       press_short,
  output logic       press_long
);

  // Wide enough for the larger of the two half-periods, never zero width.
  localparam int unsigned BLINK_W =
    max_u(1, $clog2(max_u(SLOW_HALF, FAST_HALF)));
  localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_HALF - 1);
  localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF - 1);

  press_state_e       press_state;
  mode_e              mode_q, mode_d;
  logic               led_q, led_d;
  logic [BLINK_W-1:0] blink_q, blink_d, half_last;
  logic               mode_chg;

  press_classifier #(
    .LONG_CYCLES (LONG_CYCLES)
  ) u_press (
    .clk         (clk),
    .rst         (rst),
    .btn_level   (btn_level),
    .press_short (press_short),
    .press_long  (press_long),
    .state_dbg   (press_state)
  );

`ifdef LED_DIM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d;
`endif

  always_comb begin
    mode_d = mode_q;
    if (press_short) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end else if (press_long) begin
      mode_d = MODE_OFF;
    end
    mode_chg  = (mode_d != mode_q);
    half_last = (mode_q == MODE_BLINK_FAST) ? FAST_LAST : SLOW_LAST;

    blink_d = '0;
    led_d   = 1'b0;
`ifdef LED_DIM_EN
    pwm_d   = '0;
`endif
    case (mode_d)
      MODE_OFF: led_d = 1'b0;
      MODE_ON: begin
`ifdef LED_DIM_EN
        // PWM restarts at step 0 on entry, then free-runs.
        pwm_d = mode_chg ? '0 : pwm_q + PWM_W'(1);
        led_d = (pwm_d < PWM_W'(DIM_DUTY));
`else
        led_d = 1'b1;
`endif
      end
      default: begin
        if (mode_chg) begin
          blink_d = '0;
          led_d   = 1'b1;
        end else if (blink_q == half_last) begin
          blink_d = '0;
          led_d   = ~led_q;
        end else begin
          blink_d = blink_q + BLINK_W'(1);
          led_d   = led_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      led_q   <= 1'b0;
      blink_q <= '0;
`ifdef LED_DIM_EN
      pwm_q   <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      led_q   <= led_d;
      blink_q <= blink_d;
`ifdef LED_DIM_EN
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
